microwave_timer: RTL and testbench

- Three-digit BCD countdown timer (M:ST format) for the microwave controller.
- Keypad digits are shifted in from the right while the timer is idle.
- While enabled, the timer counts down one second per tick and raises `zero` when it reaches 0:00.
- Sits between the keypad encoder and the display/magnetron control FSM.

---
 rtl/microwave_timer.sv | 99 +++++++++
 tb/tb_microwave_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// Three-digit BCD (M:ST) countdown timer: keypad digits shift in from the right
// while idle, and the count steps down once per prescaled tick while enabled.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] number,
    input  logic       loadn,
    input  logic       enable,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       zero
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
    } digits_t;

    // One-second BCD borrow chain; 0:00 is a fixed point so the count never wraps.
    function automatic digits_t bcd_dec(input digits_t d);
        digits_t r;
        r = d;
        if (d.o != 4'd0) begin
            r.o = d.o - 4'd1;
        end else if (d.t != 4'd0) begin
            r.o = 4'd9;
            r.t = d.t - 4'd1;
        end else if (d.m != 4'd0) begin
            r.o = 4'd9;
            r.t = 4'd5;
            r.m = d.m - 4'd1;
        end
        return r;
    endfunction

    function automatic digits_t shift_in(input digits_t d, input logic [3:0] n);
        digits_t r;
        r.m = d.t;
        r.t = d.o;
        r.o = n;
        return r;
    endfunction

    digits_t        cnt_q;
    digits_t        cnt_d;
    logic [PW-1:0]  presc_q;
    logic [PW-1:0]  presc_d;
    logic           loadn_q;
    logic           load_evt;
    logic           load_ok;
    logic           at_zero;

    assign at_zero  = (cnt_q == '0);
    assign load_evt = ~loadn & loadn_q;
    // Loads are only honoured while idle and only for valid BCD digits.
    assign load_ok  = load_evt & ~enable & (number <= 4'd9);

    always_comb begin
        cnt_d   = cnt_q;
        presc_d = presc_q;
        if (load_ok) begin
            cnt_d = shift_in(cnt_q, number);
        end else if (enable) begin
            if (at_zero) begin
                presc_d = '0;
            end else if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                cnt_d   = bcd_dec(cnt_q);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            cnt_q   <= '0;
            presc_q <= '0;
            loadn_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            loadn_q <= loadn;
        end
    end

    assign mins     = cnt_q.m;
    assign sec_tens = cnt_q.t;
    assign sec_ones = cnt_q.o;
    assign zero     = at_zero;

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: directed scenarios plus randomized traffic on two
// instances (1 and 4 clocks per second) against a decimal-arithmetic model.
module tb_microwave_timer;

    logic       clock;
    logic       clearn, loadn, enable;
    logic [3:0] number;
    logic [3:0] so1, st1, mn1;
    logic       z1;
    logic       c4, l4, e4;
    logic [3:0] n4;
    logic [3:0] so4, st4, mn4;
    logic       z4;

    int checks   = 0;
    int failures = 0;

    // Model: displayed value as the decimal number mins*100 + tens*10 + ones.
    int mv [2];
    int mp [2];
    bit mlq [2];

    microwave_timer #(.TICKS_PER_SEC(1)) dut (
        .clock(clock), .clearn(clearn), .number(number), .loadn(loadn),
        .enable(enable), .sec_ones(so1), .sec_tens(st1), .mins(mn1), .zero(z1)
    );

    microwave_timer #(.TICKS_PER_SEC(4)) dut4 (
        .clock(clock), .clearn(c4), .number(n4), .loadn(l4),
        .enable(e4), .sec_ones(so4), .sec_tens(st4), .mins(mn4), .zero(z4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int tps(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_reset(input int k);
        mv[k]  = 0;
        mp[k]  = 0;
        mlq[k] = 1'b1;
    endtask

    task automatic model_step(input int k, input logic clr, input logic ld,
                              input logic en, input logic [3:0] num);
        bit evt;
        if (!clr) begin
            model_reset(k);
        end else begin
            evt    = !ld && mlq[k];
            mlq[k] = ld;
            if (evt && !en && num <= 9) begin
                mv[k] = (mv[k] % 100) * 10 + int'(num);
            end else if (en) begin
                if (mv[k] == 0) begin
                    mp[k] = 0;
                end else if (mp[k] == tps(k) - 1) begin
                    mp[k] = 0;
                    // Seconds field at 00 borrows a minute and reappears as 59.
                    if (mv[k] % 100 == 0) mv[k] = mv[k] - 100 + 59;
                    else                  mv[k] = mv[k] - 1;
                end else begin
                    mp[k] = mp[k] + 1;
                end
            end
        end
    endtask

    function automatic logic [12:0] model_view(input int k);
        logic [12:0] r;
        r[12]   = (mv[k] == 0);
        r[11:8] = 4'(mv[k] / 100);
        r[7:4]  = 4'((mv[k] / 10) % 10);
        r[3:0]  = 4'(mv[k] % 10);
        return r;
    endfunction

    task automatic chk_val(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed zero/mins/tens/ones=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int k);
        if (k == 0) chk_val("model_dut1", {z1, mn1, st1, so1}, model_view(0));
        else        chk_val("model_dut4", {z4, mn4, st4, so4}, model_view(1));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step(0, clearn, loadn, enable, number);
        model_step(1, c4, l4, e4, n4);
        #1;
        chk_dut(0);
        chk_dut(1);
    endtask

    task automatic load1(input int n);
        number = 4'(n);
        loadn  = 1'b0;
        cycle();
        loadn  = 1'b1;
        cycle();
    endtask

    task automatic load4(input int n);
        n4 = 4'(n);
        l4 = 1'b0;
        cycle();
        l4 = 1'b1;
        cycle();
    endtask

    initial begin
        clearn = 1'b0; loadn = 1'b1; enable = 1'b0; number = 4'd0;
        c4     = 1'b0; l4    = 1'b1; e4     = 1'b0; n4     = 4'd0;
        model_reset(0);
        model_reset(1);
        #3;
        chk_val("reset_dut1", {z1, mn1, st1, so1}, 13'h1000);
        chk_val("reset_dut4", {z4, mn4, st4, so4}, 13'h1000);
        cycle();
        cycle();
        clearn = 1'b1;
        c4     = 1'b1;
        cycle();

        // Load 2, 1, 9 -> 2:19
        load1(2);
        load1(1);
        load1(9);
        chk_val("load_219", {z1, mn1, st1, so1}, 13'h0219);

        // Count, pause, resume across the 1:00 -> 0:59 borrow
        enable = 1'b1;
        repeat (70) cycle();
        chk_val("count_109", {z1, mn1, st1, so1}, 13'h0109);
        enable = 1'b0;
        repeat (30) cycle();
        chk_val("pause_109", {z1, mn1, st1, so1}, 13'h0109);
        enable = 1'b1;
        repeat (50) cycle();
        chk_val("resume_019", {z1, mn1, st1, so1}, 13'h0019);

        // Asynchronous clear mid-count
        clearn = 1'b0;
        model_reset(0);
        #1;
        chk_val("async_clear", {z1, mn1, st1, so1}, 13'h1000);
        enable = 1'b0;
        cycle();
        clearn = 1'b1;
        repeat (10) cycle();
        chk_val("clear_hold", {z1, mn1, st1, so1}, 13'h1000);

        // 0:27 reaches zero after exactly 27 enabled clocks and stays there
        load1(2);
        load1(7);
        chk_val("load_027", {z1, mn1, st1, so1}, 13'h0027);
        enable = 1'b1;
        repeat (26) cycle();
        chk_val("count_001", {z1, mn1, st1, so1}, 13'h0001);
        cycle();
        chk_val("reach_zero", {z1, mn1, st1, so1}, 13'h1000);
        repeat (13) cycle();
        chk_val("zero_hold", {z1, mn1, st1, so1}, 13'h1000);
        enable = 1'b0;
        cycle();

        // Load strobe edge detection, invalid digit, load while enabled
        number = 4'd5;
        loadn  = 1'b0;
        repeat (3) cycle();
        loadn  = 1'b1;
        cycle();
        chk_val("held_load", {z1, mn1, st1, so1}, 13'h0005);
        load1(12);
        chk_val("invalid_digit", {z1, mn1, st1, so1}, 13'h0005);
        number = 4'd3;
        enable = 1'b1;
        loadn  = 1'b0;
        cycle();
        enable = 1'b0;
        loadn  = 1'b1;
        cycle();
        chk_val("load_enabled", {z1, mn1, st1, so1}, 13'h0004);

        // Prescaled instance: 0:02 with a pause mid-period
        load4(2);
        chk_val("p4_load", {z4, mn4, st4, so4}, 13'h0002);
        e4 = 1'b1;
        repeat (3) cycle();
        chk_val("p4_pre_tick", {z4, mn4, st4, so4}, 13'h0002);
        cycle();
        chk_val("p4_tick1", {z4, mn4, st4, so4}, 13'h0001);
        repeat (2) cycle();
        e4 = 1'b0;
        repeat (5) cycle();
        e4 = 1'b1;
        cycle();
        chk_val("p4_after_pause", {z4, mn4, st4, so4}, 13'h0001);
        cycle();
        chk_val("p4_zero", {z4, mn4, st4, so4}, 13'h1000);
        e4 = 1'b0;
        cycle();

        // Randomized traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            clearn = ($urandom_range(0, 80) != 0);
            loadn  = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 2) == 0);
            number = 4'($urandom_range(0, 15));
            c4     = ($urandom_range(0, 80) != 0);
            l4     = 1'($urandom_range(0, 1));
            e4     = ($urandom_range(0, 1) == 0);
            n4     = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
